// File: rtl/reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter
//
// Purpose:
//   Arbitrates two requesters (A and B) for a shared bank of four registers
//   that all share one function code (FunSel) and one data bus (I). A winning
//   request becomes a one-cycle grant that drives a one-hot enable (E) to the
//   targeted register. Every output is registered.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous eligible requests are
//                        granted to the requester opposite to LAST.
//                        When undefined, A has fixed priority over B.
//
// Ports:
//   CLK            in   clock, all state changes on the rising edge
//   RST            in   synchronous, active-high reset
//   REQ_A/REQ_B    in   access request from requester A / B
//   OP_A/OP_B      in   [1:0] requested FunSel code (0 dec,1 inc,2 load,3 clr)
//   SEL_A/SEL_B    in   [1:0] target register index 0-3
//   D_A/D_B        in   [N-1:0] load data
//   GNT_A/GNT_B    out  one-cycle grant pulse
//   E              out  [3:0] one-hot register enable, 0 when no grant
//   FunSel         out  [1:0] function code shared by all registers
//   I              out  [N-1:0] data shared by all registers
//   LAST           out  last granted requester (0=A, 1=B)
// ---------------------------------------------------------------------------
module reg_access_arbiter #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ_A,
    input  logic         REQ_B,
    input  logic [1:0]   OP_A,
    input  logic [1:0]   OP_B,
    input  logic [1:0]   SEL_A,
    input  logic [1:0]   SEL_B,
    input  logic [N-1:0] D_A,
    input  logic [N-1:0] D_B,
    output logic         GNT_A,
    output logic         GNT_B,
    output logic [3:0]   E,
    output logic [1:0]   FunSel,
    output logic [N-1:0] I,
    output logic         LAST
);

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_A,
        WIN_B
    } win_t;

    win_t         win;
    logic         elig_a;
    logic         elig_b;
    logic         gnt_a_next;
    logic         gnt_b_next;
    logic [3:0]   e_next;
    logic [1:0]   funsel_next;
    logic [N-1:0] i_next;
    logic         last_next;

    // A request whose grant is currently showing has already been consumed,
    // so a held REQ is not eligible again until the grant cycle is over.
    always_comb begin
        elig_a = REQ_A & ~GNT_A;
        elig_b = REQ_B & ~GNT_B;
        win    = WIN_NONE;
        if (elig_a && elig_b) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = LAST ? WIN_A : WIN_B;
`else
            win = WIN_A;
`endif
        end else if (elig_a) begin
            win = WIN_A;
        end else if (elig_b) begin
            win = WIN_B;
        end
    end

    // Build the next output set from the winner; FunSel, I and LAST keep
    // their values when nobody is granted.
    always_comb begin
        gnt_a_next  = 1'b0;
        gnt_b_next  = 1'b0;
        e_next      = 4'b0000;
        funsel_next = FunSel;
        i_next      = I;
        last_next   = LAST;
        case (win)
            WIN_A: begin
                gnt_a_next  = 1'b1;
                e_next      = 4'b0001 << SEL_A;
                funsel_next = OP_A;
                i_next      = D_A;
                last_next   = 1'b0;
            end
            WIN_B: begin
                gnt_b_next  = 1'b1;
                e_next      = 4'b0001 << SEL_B;
                funsel_next = OP_B;
                i_next      = D_B;
                last_next   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset drops any grant in flight and leaves LAST=1 so that A wins the
    // first contended round-robin arbitration.
    always_ff @(posedge CLK) begin
        if (RST) begin
            GNT_A  <= 1'b0;
            GNT_B  <= 1'b0;
            E      <= 4'b0000;
            FunSel <= 2'b00;
            I      <= '0;
            LAST   <= 1'b1;
        end else begin
            GNT_A  <= gnt_a_next;
            GNT_B  <= gnt_b_next;
            E      <= e_next;
            FunSel <= funsel_next;
            I      <= i_next;
            LAST   <= last_next;
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_access_arbiter
//
// Drives two requesters that hold their request until granted, predicts the
// grant sequence with a transaction-level model, and checks the DUT outputs
// against a queue of expected grants from an independent monitor process.
// ---------------------------------------------------------------------------
module tb_reg_access_arbiter;

   localparam int N = 8;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         reqA, reqB;
   logic [1:0]   opA, opB, selA, selB;
   logic [N-1:0] dA, dB;
   logic         gntA, gntB;
   logic [3:0]   e;
   logic [1:0]   funSel;
   logic [N-1:0] iBus;
   logic         last;

   typedef struct {
      logic         isB;
      logic [1:0]   sel;
      logic [1:0]   op;
      logic [N-1:0] d;
   } grant_t;

   grant_t expQ[$];

   int vectors    = 0;
   int miscompares = 0;

   // Transaction-level model state: who was last served and whose grant
   // is currently visible (that requester's held REQ is already consumed).
   logic mLast;
   logic mShowA, mShowB;

   reg_access_arbiter #(.N(N)) dut (
      .CLK(clk), .RST(rst),
      .REQ_A(reqA), .REQ_B(reqB),
      .OP_A(opA), .OP_B(opB),
      .SEL_A(selA), .SEL_B(selB),
      .D_A(dA), .D_B(dB),
      .GNT_A(gntA), .GNT_B(gntB),
      .E(e), .FunSel(funSel), .I(iBus), .LAST(last)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and predict what the
   // following rising edge must produce.
   task automatic applyStimulus(
      input logic rstV,
      input logic rqA, input logic [1:0] oA, input logic [1:0] sA, input logic [N-1:0] vA,
      input logic rqB, input logic [1:0] oB, input logic [1:0] sB, input logic [N-1:0] vB,
      output logic gotA, output logic gotB);
      grant_t g;
      logic wantA, wantB;
      @(negedge clk);
      rst = rstV;
      reqA = rqA; opA = oA; selA = sA; dA = vA;
      reqB = rqB; opB = oB; selB = sB; dB = vB;
      gotA = 1'b0;
      gotB = 1'b0;
      if (rstV) begin
         mShowA = 1'b0;
         mShowB = 1'b0;
         mLast  = 1'b1;
      end else begin
         wantA = rqA && !mShowA;
         wantB = rqB && !mShowB;
         if (wantA && wantB) begin
            if (RR) begin
               gotA = (mLast == 1'b1);
               gotB = !gotA;
            end else begin
               gotA = 1'b1;
            end
         end else begin
            gotA = wantA;
            gotB = wantB;
         end
         if (gotA) begin
            g.isB = 1'b0; g.sel = sA; g.op = oA; g.d = vA;
            expQ.push_back(g);
            mLast = 1'b0;
         end else if (gotB) begin
            g.isB = 1'b1; g.sel = sB; g.op = oB; g.d = vB;
            expQ.push_back(g);
            mLast = 1'b1;
         end
         mShowA = gotA;
         mShowB = gotB;
      end
   endtask

   // Monitor: one sample per cycle, just after the rising edge. A visible
   // grant pops the next expected grant; otherwise the bank must be idle
   // with FunSel, I and LAST holding the last expected values.
   initial begin
      grant_t g;
      logic [1:0]   expFs   = 2'b00;
      logic [N-1:0] expI    = '0;
      logic         expLast = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            checkOutput("rst_gnt_a", gntA, 0);
            checkOutput("rst_gnt_b", gntB, 0);
            checkOutput("rst_e", e, 0);
            checkOutput("rst_funsel", funSel, 0);
            checkOutput("rst_i", iBus, 0);
            checkOutput("rst_last", last, 1);
            expFs = 2'b00; expI = '0; expLast = 1'b1;
            expQ.delete();
         end else if (gntA === 1'b1 || gntB === 1'b1) begin
            checkOutput("one_grant", gntA & gntB, 0);
            if (expQ.size() == 0) begin
               checkOutput("unexpected_grant", {gntB, gntA}, 0);
            end else begin
               g = expQ.pop_front();
               checkOutput("gnt_a", gntA, !g.isB);
               checkOutput("gnt_b", gntB, g.isB);
               checkOutput("e_onehot", e, 32'd1 << g.sel);
               checkOutput("funsel", funSel, g.op);
               checkOutput("i_data", iBus, g.d);
               checkOutput("last", last, g.isB);
               expFs = g.op; expI = g.d; expLast = g.isB;
            end
         end else begin
            checkOutput("idle_e", e, 0);
            checkOutput("hold_funsel", funSel, expFs);
            checkOutput("hold_i", iBus, expI);
            checkOutput("hold_last", last, expLast);
            checkOutput("missing_grant", expQ.size(), 0);
            expQ.delete();
         end
      end
   end

   initial begin
      logic gA, gB;
      logic pendA, pendB;
      logic [1:0] rOpA, rOpB, rSelA, rSelB;
      logic [N-1:0] rDA, rDB;
      logic rstV;

      rst = 1'b1;
      reqA = 1'b0; reqB = 1'b0;
      opA = 2'b00; opB = 2'b00; selA = 2'b00; selB = 2'b00;
      dA = '0; dB = '0;
      mLast = 1'b1; mShowA = 1'b0; mShowB = 1'b0;

      // Reset, then a single load request to register 1.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, gA, gB);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, gA, gB);
      applyStimulus(0, 1, 2'd2, 2'd1, 8'h5A, 0, 0, 0, 0, gA, gB);
      applyStimulus(0, 0, 2'd2, 2'd1, 8'h5A, 0, 0, 0, 0, gA, gB);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, gA, gB);

      // Lone requester B held for six cycles: granted every other cycle.
      for (int k = 0; k < 6; k++)
         applyStimulus(0, 0, 0, 0, 0, 1, 2'd1, 2'd3, 8'hC3, gA, gB);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, gA, gB);

      // Continuous contention from both requesters after a fresh reset.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, gA, gB);
      for (int k = 0; k < 8; k++)
         applyStimulus(0, 1, 2'd0, 2'd0, 8'h21, 1, 2'd1, 2'd2, 8'h42, gA, gB);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, gA, gB);

      // Same target from both sides, each held until its own grant.
      pendA = 1'b1; pendB = 1'b1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, pendA, 2'd3, 2'd2, 8'h00, pendB, 2'd2, 2'd2, 8'h11, gA, gB);
         if (gA) pendA = 1'b0;
         if (gB) pendB = 1'b0;
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, gA, gB);

      // Reset during a grant with A's request held throughout.
      applyStimulus(0, 1, 2'd1, 2'd0, 8'h77, 0, 0, 0, 0, gA, gB);
      applyStimulus(1, 1, 2'd1, 2'd0, 8'h77, 0, 0, 0, 0, gA, gB);
      applyStimulus(0, 1, 2'd1, 2'd0, 8'h77, 0, 0, 0, 0, gA, gB);
      applyStimulus(0, 0, 2'd1, 2'd0, 8'h77, 0, 0, 0, 0, gA, gB);

      // Randomized traffic: requesters hold fields until granted; idle
      // requesters wiggle their fields to prove they are ignored.
      pendA = 1'b0; pendB = 1'b0;
      rOpA = 0; rOpB = 0; rSelA = 0; rSelB = 0; rDA = 0; rDB = 0;
      for (int k = 0; k < 500; k++) begin
         rstV = ($urandom_range(0, 49) == 0);
         if (!pendA) begin
            rOpA = 2'($urandom); rSelA = 2'($urandom); rDA = N'($urandom);
            pendA = ($urandom_range(0, 2) != 0);
         end
         if (!pendB) begin
            rOpB = 2'($urandom); rSelB = 2'($urandom); rDB = N'($urandom);
            pendB = ($urandom_range(0, 2) != 0);
         end
         applyStimulus(rstV, pendA, rOpA, rSelA, rDA, pendB, rOpB, rSelB, rDB, gA, gB);
         if (gA) pendA = 1'b0;
         if (gB) pendB = 1'b0;
      end

      for (int k = 0; k < 3; k++)
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, gA, gB);
      @(negedge clk);
      checkOutput("queue_drained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the data width of the shared register bank.
REQ-002 The block SHALL have port CLK, input, 1 bit, meaning the single clock; all state changes on posedge.
REQ-003 The block SHALL have port RST, input, 1 bit, meaning synchronous, active-high reset.
REQ-004 The block SHALL have ports REQ_A and REQ_B, each input, 1 bit, meaning the access request from requester A or B.
REQ-005 The block SHALL have ports OP_A and OP_B, each input, 2 bits, meaning the requested FunSel code (0 dec, 1 inc, 2 load, 3 clear).
REQ-006 The block SHALL have ports SEL_A and SEL_B, each input, 2 bits, meaning the target register index 0-3.
REQ-007 The block SHALL have ports D_A and D_B, each input, N bits, meaning the load data for OP=2.
REQ-008 The block SHALL have ports GNT_A and GNT_B, each output, 1 bit, meaning a one-cycle grant pulse.
REQ-009 The block SHALL have port E, output, 4 bits, meaning a one-hot enable to registers 0-3.
REQ-010 The block SHALL have port FunSel, output, 2 bits, meaning the function code shared by all four registers.
REQ-011 The block SHALL have port I, output, N bits, meaning the data shared by all four registers.
REQ-012 The block SHALL have port LAST, output, 1 bit, meaning the last granted requester (0=A, 1=B).

Function
REQ-013 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.
REQ-014 A request sampled at edge t SHALL produce GNT_x=1, E=onehot(SEL_x), FunSel=OP_x and I=D_x during cycle t..t+1; the register then updates at edge t+1.
REQ-015 At most one of GNT_A/GNT_B SHALL be high in any cycle; E SHALL be 0 whenever both grants are low.
REQ-016 A requester SHALL hold REQ, OP, SEL and D stable from assertion until it sees its GNT.
REQ-017 REQ_x SHALL be ignored at any edge where GNT_x is currently high, because that request is consumed; a lone requester is therefore granted at most every other cycle.
REQ-018 Arbitration between simultaneous eligible requests SHALL follow the Configuration section; a single eligible request SHALL always win.
REQ-019 A grant SHALL set LAST to the winner at the same edge; LAST SHALL hold when no grant occurs.
REQ-020 FunSel and I SHALL hold their previous values while E=0.
REQ-021 Both requesters targeting the same SEL SHALL be serialized, never merged; each receives its own grant cycle.
REQ-022 With no requests, the block SHALL idle with all grants and E at 0.

Reset
REQ-023 When RST=1 at an edge, the outputs SHALL become GNT_A=0, GNT_B=0, E=0, FunSel=0, I=0 and LAST=1 (so A wins first under round-robin).
REQ-024 A grant in flight when RST is asserted SHALL be dropped; pending requests SHALL be re-arbitrated only after the first edge with RST=0.
REQ-025 RST SHALL take priority over all requests at the same edge.

Configuration
REQ-026 The macro ARB_ROUND_ROBIN_EN SHALL control arbitration between simultaneous eligible requests.
REQ-027 With ARB_ROUND_ROBIN_EN defined, simultaneous eligible requests SHALL grant the requester opposite to LAST.
REQ-028 Without ARB_ROUND_ROBIN_EN, simultaneous eligible requests SHALL grant A (fixed priority), and B SHALL wait until A is ineligible.
REQ-029 The port list and latency SHALL be identical with and without ARB_ROUND_ROBIN_EN.

Verification
REQ-030 A single request: RST pulse, then REQ_A=1, OP_A=2, SEL_A=1, D_A=0x5A -> next cycle GNT_A=1, E=0010, FunSel=2, I=0x5A; following cycle E=0000, LAST=0.
REQ-031 Contention with ARB_ROUND_ROBIN_EN: REQ_A=REQ_B=1 held continuously after reset -> grants alternate A, B, A, B on consecutive cycles; GNT_A and GNT_B are never both high.
REQ-032 Contention without ARB_ROUND_ROBIN_EN: REQ_A held high, REQ_B=1 -> A is granted every other cycle; B is granted only in the cycles where A is ineligible (REQ-017).
REQ-033 Lone requester: REQ_B=1 held for 6 cycles, OP_B=1, SEL_B=3 -> GNT_B pulses at cycles 1, 3, 5 and E=1000 only in those cycles.
REQ-034 Same-target serialization: A OP=3 SEL=2 and B OP=2 SEL=2 D=0x11 simultaneously -> two separate grant cycles; the final I/FunSel order matches the arbitration mode.
REQ-035 Reset mid-operation: RST=1 in the cycle GNT_A=1 -> next cycle all outputs are 0 with LAST=1; a held REQ_A is granted 1 cycle after RST falls.
